// File: rtl/mips_gpio_mmio.sv
// Purpose : address-decoded GPIO register block: synchronised inputs with sticky change flags, writable outputs.
// Latency : reads return 1 cycle after the strobe; writes land at the sampling edge; inputs visible 2 edges after change.
// Backpres: none; one access per strobe cycle, back-to-back reads every cycle accepted.
//
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   addr              byte address; hit is its combinational window decode
//   rd_en / wr_en     single-cycle access strobes; wr_data is the write word
//   rd_data/rd_valid  registered read response
//   GPIO_i / GPIO_o   packed input channels (IN_WIDTH each) and output words (DATA_WIDTH each)
//   change_irq        registered OR of the change flags
module mips_gpio_mmio #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    IN_CHANNELS  = 2,
    parameter int                    IN_WIDTH     = 8,
    parameter int                    OUT_CHANNELS = 2,
    parameter bit                    SIGN_EXT     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_WIDTH-1:0]                addr,
    input  logic                                 wr_en,
    input  logic                                 rd_en,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic                                 rd_valid,
    output logic                                 hit,
    input  logic [IN_CHANNELS*IN_WIDTH-1:0]      GPIO_i,
    output logic [OUT_CHANNELS*DATA_WIDTH-1:0]   GPIO_o,
    output logic                                 change_irq
);

    localparam int                 WW         = DATA_WIDTH - 2;
    localparam int                 NUM_REGS   = IN_CHANNELS + OUT_CHANNELS + 1;
    localparam logic [WW-1:0]      STATUS_IDX = WW'(IN_CHANNELS);
    localparam logic [WW-1:0]      NUM_REGS_W = WW'(NUM_REGS);

    // Unsigned wrap makes addresses below BASE_ADDR decode as huge offsets,
    // so a single upper-bound compare covers both sides of the window.
    logic [DATA_WIDTH-1:0] offset;
    logic [WW-1:0]         word_idx;

    assign offset   = addr - BASE_ADDR;
    assign word_idx = offset[DATA_WIDTH-1:2];
    assign hit      = (offset[1:0] == 2'b00) && (word_idx < NUM_REGS_W);

    logic rd_acc;
    logic wr_acc;
    logic status_sel;

    assign rd_acc     = rd_en && hit;
    assign wr_acc     = wr_en && hit;
    assign status_sel = (word_idx == STATUS_IDX);

    // Input synchroniser: s1/s2 are the metastability pair, s3 is the
    // previous s2 sample used only for change detection.
    logic [IN_WIDTH-1:0]   s1 [IN_CHANNELS];
    logic [IN_WIDTH-1:0]   s2 [IN_CHANNELS];
    logic [IN_WIDTH-1:0]   s3 [IN_CHANNELS];
    logic [DATA_WIDTH-1:0] in_ext [IN_CHANNELS];
    logic [IN_CHANNELS-1:0] change;
    logic [IN_CHANNELS-1:0] flags;
    logic [IN_CHANNELS-1:0] clr_mask;
    logic [DATA_WIDTH-1:0] out_reg [OUT_CHANNELS];
    logic [DATA_WIDTH-1:0] rd_mux;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < IN_CHANNELS; k++) begin
                s1[k] <= '0;
                s2[k] <= '0;
                s3[k] <= '0;
            end
        end else begin
            for (int k = 0; k < IN_CHANNELS; k++) begin
                s1[k] <= GPIO_i[k*IN_WIDTH +: IN_WIDTH];
                s2[k] <= s1[k];
                s3[k] <= s2[k];
            end
        end
    end

    genvar gk;
    generate
        for (gk = 0; gk < IN_CHANNELS; gk++) begin : g_ext
            if (IN_WIDTH < DATA_WIDTH) begin : g_pad
                assign in_ext[gk] = {{(DATA_WIDTH-IN_WIDTH){SIGN_EXT & s2[gk][IN_WIDTH-1]}}, s2[gk]};
            end else begin : g_full
                assign in_ext[gk] = s2[gk];
            end
        end
        for (gk = 0; gk < OUT_CHANNELS; gk++) begin : g_out
            assign GPIO_o[gk*DATA_WIDTH +: DATA_WIDTH] = out_reg[gk];
        end
    endgenerate

    always_comb begin
        change = '0;
        for (int k = 0; k < IN_CHANNELS; k++) begin
            change[k] = (s2[k] != s3[k]);
        end
    end

    // A STATUS read clears exactly what it returns; a STATUS write clears
    // the bits written as 1. Both may hit in the same cycle.
    always_comb begin
        clr_mask = '0;
        if (rd_acc && status_sel) begin
            clr_mask = flags;
        end
        if (wr_acc && status_sel) begin
            clr_mask = clr_mask | wr_data[IN_CHANNELS-1:0];
        end
    end

    // Set wins over clear: a fresh change re-asserts the flag after masking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags      <= '0;
            change_irq <= 1'b0;
        end else begin
            flags      <= (flags & ~clr_mask) | change;
            change_irq <= |flags;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < OUT_CHANNELS; k++) begin
                out_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < OUT_CHANNELS; k++) begin
                if (wr_acc && (word_idx == WW'(IN_CHANNELS + 1 + k))) begin
                    out_reg[k] <= wr_data;
                end
            end
        end
    end

    // Mux uses pre-edge register values, so a read colliding with a write
    // to the same register returns the old contents.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < IN_CHANNELS; k++) begin
            if (word_idx == WW'(k)) begin
                rd_mux = in_ext[k];
            end
        end
        if (status_sel) begin
            rd_mux[IN_CHANNELS-1:0] = flags;
        end
        for (int k = 0; k < OUT_CHANNELS; k++) begin
            if (word_idx == WW'(IN_CHANNELS + 1 + k)) begin
                rd_mux = out_reg[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: doc/mips_gpio_mmio.md
# mips_gpio_mmio

Parametrised memory-mapped GPIO bridge for the multicycle MIPS core. It replaces the direct 8-bit input sign-extension into the datapath with a bus-attached register block. The block has N synchronised input channels with change detection, M writable output registers and a registered read port. It sits between the datapath's memory address/data path and the board I/O, decoded by address window.

## Interface
- DATA_WIDTH, 32: bus data and address width.
- IN_CHANNELS, 2: number of input channels (1–16).
- IN_WIDTH, 8: width of each input channel (1–DATA_WIDTH).
- OUT_CHANNELS, 2: number of output registers (1–16).
- SIGN_EXT, 1: 1 = sign-extend inputs to DATA_WIDTH, 0 = zero-extend.
- BASE_ADDR, 32'h1001_0000: byte address of register 0, word-aligned.

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low; all registers cleared while low.
- addr  in  DATA_WIDTH  byte address from datapath.
- wr_en  in  1  write strobe, one cycle per access.
- rd_en  in  1  read strobe, one cycle per access.
- wr_data  in  DATA_WIDTH  write data.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  high one cycle when rd_data holds a response.
- hit  out  1  combinational: addr decodes into this block.
- GPIO_i  in  IN_CHANNELS*IN_WIDTH  asynchronous inputs, channel k at bits [k*IN_WIDTH +: IN_WIDTH].
- GPIO_o  out  OUT_CHANNELS*DATA_WIDTH  output registers, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- change_irq  out  1  OR of all status flags, registered.

## Operation
- Word offset w = (addr − BASE_ADDR) >> 2. Register map:
  - w = 0 .. IN_CHANNELS−1: input k (read-only).
  - w = IN_CHANNELS: STATUS, bit k = change flag of channel k, upper bits read 0.
  - w = IN_CHANNELS+1 .. IN_CHANNELS+OUT_CHANNELS: output registers (read/write).
- hit = 1 only if addr[1:0] = 0 and 0 ≤ w < IN_CHANNELS+OUT_CHANNELS+1. Misaligned or out-of-window addresses: hit = 0, writes ignored, reads produce no rd_valid.
- Input path, per channel: stage s1 ← GPIO_i, s2 ← s1, s3 ← s2. The readable value is s2, extended per SIGN_EXT.
- Change detect: flag k sets on the edge where s2 ≠ s3 (any bit differs). The flag is sticky.
- Flag clear: a STATUS read clears exactly the flags returned by that read. A STATUS write clears the flags at bit positions written 1 (W1C).
- Set wins over clear: a change detected on the same edge as a clear leaves that flag set.
- Writes to input registers are ignored. Writing an output register updates the full word.
- rd_en and wr_en in the same cycle to the same register: the write is performed, and rd_data returns the pre-write value.
- rd_en & !hit: rd_valid stays 0 and rd_data holds its previous value.

## Timing
- Reset values: rd_data = 0, rd_valid = 0, change_irq = 0, GPIO_o = 0, s1/s2/s3 = 0, all flags = 0. hit depends only on addr.
- Reset asserted mid-access: the access is aborted, with no rd_valid after release.
- Read latency is 1 cycle. With rd_en & hit sampled at edge n, rd_data/rd_valid are valid after edge n; rd_valid drops after edge n+1 unless another read is issued. Back-to-back reads every cycle are supported.
- Write takes effect at the sampling edge, so GPIO_o changes after edge n.
- Input latency: a GPIO_i change stable before edge n appears in s2 after edge n+1, so it is readable in the cycle after edge n+1. The flag sets at edge n+2, and change_irq follows at edge n+3.
- Inputs changing every cycle: the flag stays set, and data reflects the latest synchronised sample.

## Test plan
- Reset: hold rst = 0 with GPIO_i toggling → all outputs 0. Release, read STATUS → rd_data = 0, rd_valid = 1 one cycle later.
- Sign extension: IN_WIDTH = 8, SIGN_EXT = 1, GPIO_i ch0 = 8'hF0 → read addr 0x1001_0000 gives 32'hFFFF_FFF0. With SIGN_EXT = 0 → 32'h0000_00F0.
- Change flag: toggle ch1 once → STATUS = 32'h2 and change_irq = 1. Read again → 32'h0 and change_irq falls. W1C write of 32'h2 clears a re-set flag.
- Set-vs-clear race: a ch0 edge lands on the same cycle as a STATUS read that returns bit0 = 1 → bit0 remains 1 on the next read.
- Output and decode: write 32'hDEAD_BEEF to offset 0x0C (out0 when IN_CHANNELS = 2) → GPIO_o[31:0] = 32'hDEAD_BEEF next cycle, readback matches. Writes to 0x0E (misaligned) and 0x14 (out of window) leave hit = 0, produce no change and no rd_valid.
- Simultaneous read/write to out1: old value returned, new value present on the following read.
